// File: rtl/sonar_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sonar_scan_ctrl
//
// Sequencer for a sweeping sonar. At each servo position it starts a distance
// measurement, sends the result over the serial link, waits for a fixed
// interval and then steps the servo. The servo sweeps back and forth across
// the positions 0..7.
//
// Parameters
//   INTERVALO  clock cycles spent waiting between positions
//   TIMEOUT    max clock cycles to wait for fim_medida before flagging an error
//
// Ports
//   clock            system clock; all state changes on the rising edge
//   reset            asynchronous reset, active low
//   ligar            level enable; 1 = keep scanning
//   fim_medida       1-cycle pulse: measurement finished
//   fim_transmissao  1-cycle pulse: serial transmission finished
//   medir            1-cycle pulse: start a measurement
//   transmitir       1-cycle pulse: start a transmission
//   posicao          current servo position index (0..7)
//   fim_posicao      1-cycle pulse when posicao first shows a sweep end (7 or 0)
//   erro_medida      1 = last measurement timed out; held until the next success
//   db_estado        current state encoding, for debug
//
// Every output comes straight from a flop or from a decode of the state flop,
// so there is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module sonar_scan_ctrl #(
   parameter int unsigned INTERVALO = 50000000,
   parameter int unsigned TIMEOUT   = 2000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ligar,
   input  logic       fim_medida,
   input  logic       fim_transmissao,
   output logic       medir,
   output logic       transmitir,
   output logic [2:0] posicao,
   output logic       fim_posicao,
   output logic       erro_medida,
   output logic [3:0] db_estado
);

   // Each counter only has to reach PARAM-1, and it stops there, so it never
   // wraps during one visit to its state.
   localparam int unsigned TO_W = (TIMEOUT   > 1) ? $clog2(TIMEOUT)   : 1;
   localparam int unsigned IV_W = (INTERVALO > 1) ? $clog2(INTERVALO) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
   localparam logic [IV_W-1:0] IV_LAST = IV_W'(INTERVALO - 1);

   typedef enum logic [3:0] {
      INICIAL        = 4'd0,
      PREPARA        = 4'd1,
      MEDE           = 4'd2,
      AGUARDA_MEDIDA = 4'd3,
      TRANSMITE      = 4'd4,
      AGUARDA_TX     = 4'd5,
      ESPERA         = 4'd6,
      AVANCA         = 4'd7
   } state_t;

   state_t          state_q,   state_d;
   logic [TO_W-1:0] to_cnt_q,  to_cnt_d;
   logic [IV_W-1:0] iv_cnt_q,  iv_cnt_d;
   logic [2:0]      pos_q,     pos_d;
   logic            dir_q,     dir_d;      // 0 = counting up, 1 = counting down
   logic            fim_pos_q, fim_pos_d;
   logic            erro_q,    erro_d;
   logic [2:0]      pos_step;

   // The next position, one step in the current direction
   assign pos_step = dir_q ? (pos_q - 3'd1) : (pos_q + 3'd1);

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= INICIAL;
         to_cnt_q  <= '0;
         iv_cnt_q  <= '0;
         pos_q     <= 3'd0;
         dir_q     <= 1'b0;
         fim_pos_q <= 1'b0;
         erro_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         to_cnt_q  <= to_cnt_d;
         iv_cnt_q  <= iv_cnt_d;
         pos_q     <= pos_d;
         dir_q     <= dir_d;
         fim_pos_q <= fim_pos_d;
         erro_q    <= erro_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      to_cnt_d  = to_cnt_q;
      iv_cnt_d  = iv_cnt_q;
      pos_d     = pos_q;
      dir_d     = dir_q;
      fim_pos_d = 1'b0;        // pulse: high for exactly one cycle
      erro_d    = erro_q;

      case (state_q)
         INICIAL: begin
            if (ligar) state_d = PREPARA;
         end

         PREPARA: begin
            to_cnt_d = '0;
            iv_cnt_d = '0;
            state_d  = MEDE;
         end

         MEDE: begin
            state_d = AGUARDA_MEDIDA;
         end

         AGUARDA_MEDIDA: begin
            // fim_medida is checked first, so it wins over a timeout that
            // happens in the same cycle.
            if (fim_medida) begin
               erro_d  = 1'b0;
               state_d = TRANSMITE;
            end else if (to_cnt_q == TO_LAST) begin
               erro_d  = 1'b1;
               state_d = TRANSMITE;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end

         TRANSMITE: begin
            state_d = AGUARDA_TX;
         end

         AGUARDA_TX: begin
            if (fim_transmissao) state_d = ESPERA;
         end

         ESPERA: begin
            if (iv_cnt_q == IV_LAST) state_d = AVANCA;
            else                     iv_cnt_d = iv_cnt_q + IV_W'(1);
         end

         AVANCA: begin
            pos_d = pos_step;
            // Turn around at the ends. fim_pos is registered together with
            // pos, so both show up in the same cycle.
            if (pos_step == 3'd7) begin
               dir_d     = 1'b1;
               fim_pos_d = 1'b1;
            end else if (pos_step == 3'd0) begin
               dir_d     = 1'b0;
               fim_pos_d = 1'b1;
            end
            // ligar is only looked at here, so dropping it in the middle of a
            // position still lets that position finish.
            state_d = ligar ? PREPARA : INICIAL;
         end

         default: begin
            state_d = INICIAL;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs, all taken from registered state
   // -------------------------------------------------------------------------
   assign medir       = (state_q == MEDE);
   assign transmitir  = (state_q == TRANSMITE);
   assign posicao     = pos_q;
   assign fim_posicao = fim_pos_q;
   assign erro_medida = erro_q;
   assign db_estado   = state_q;

endmodule
